// File: rtl/scan_response_collector_if.sv
// Response stream from the scan response collector to its consumer.
// Head word plus pattern index, valid/ready handshake.
interface scan_response_collector_if #(
    parameter int CHAIN_LEN = 11
) ();
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;
    logic [19:0]          resp_idx;

    modport master (output resp_valid, resp_data, resp_idx, input resp_ready);
    modport slave  (input resp_valid, resp_data, resp_idx, output resp_ready);
endinterface

// File: rtl/scan_response_collector.sv
// Generic synchronous FIFO (DEPTH must be a power of two).
// Latency: pushed data visible at head 1 clk after the push edge.
// Backpressure: push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - (AW+1)'(1);
        end
    end
endmodule

// Deserializes scan_so unloads, length-checks, buffers and MISR-folds each word.
// Latency: word and signature visible 1 clk after test_se falls.
// Backpressure: 2-deep buffer; a good word arriving when full is dropped and flagged.
module scan_response_collector #(
    parameter int          CHAIN_LEN  = 11,
    parameter bit          SKIP_FIRST = 1'b1,
    parameter logic [15:0] POLY       = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_adpll_lock,
    input  logic        i_shift_en,
    input  logic        i_test_se,
    input  logic        i_scan_done,
    input  logic        i_scan_so,
    input  logic [15:0] i_exp_sig,
    scan_response_collector_if.master resp,
    output logic [15:0] o_signature,
    output logic        o_sig_valid,
    output logic        o_pass,
    output logic        o_len_err,
    output logic        o_overflow,
    output logic        o_lock_lost
);
    localparam int CW  = $clog2(CHAIN_LEN + 2);
    localparam int NCH = (CHAIN_LEN + 15) / 16;
    localparam logic [CW-1:0] LEN     = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LEN_SAT = CW'(CHAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

    state_t               r_state;
    logic                 r_test_se_q;
    logic [CHAIN_LEN-1:0] r_data;
    logic [CW-1:0]        r_bit_cnt;
    logic [19:0]          r_pat_cnt;
    logic                 r_done_pend;
    logic [15:0]          r_sig;
    logic                 r_sig_valid;
    logic                 r_pass;
    logic                 r_len_err;
    logic                 r_overflow;
    logic                 r_lock_lost;

    logic                 w_sample;
    logic                 w_boundary;
    logic                 w_skip;
    logic                 w_good;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic [CHAIN_LEN-1:0] w_data_shift;
    logic [CW-1:0]        w_cnt_inc;
    logic [NCH*16-1:0]    w_data_ext;
    logic [15:0]          w_fold;
    logic [15:0]          w_sig_next;
    logic [15:0]          w_sig_upd;
    logic [CHAIN_LEN+19:0] w_head;

    assign w_sample     = i_adpll_lock & i_shift_en & i_test_se;
    assign w_boundary   = (r_state == SHIFT) & r_test_se_q & ~i_test_se;
    assign w_skip       = SKIP_FIRST & (r_pat_cnt == 20'd0);
    assign w_good       = ~w_skip & (r_bit_cnt == LEN);
    assign w_pop        = resp.resp_valid & resp.resp_ready;
    assign w_room       = ~w_full | w_pop;
    assign w_push       = w_boundary & i_adpll_lock & w_good & w_room;
    assign w_data_shift = {i_scan_so, r_data[CHAIN_LEN-1:1]};
    assign w_cnt_inc    = (r_bit_cnt == LEN_SAT) ? r_bit_cnt : r_bit_cnt + CW'(1);

    // Chains longer than 16 bits fold into the signature 16 bits at a time.
    always_comb begin
        w_data_ext = '0;
        w_data_ext[CHAIN_LEN-1:0] = r_data;
        w_fold = '0;
        for (int k = 0; k < NCH; k++) w_fold = w_fold ^ w_data_ext[16*k +: 16];
    end

    assign w_sig_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? POLY : 16'h0000) ^ w_fold;
    assign w_sig_upd  = w_good ? w_sig_next : r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_test_se_q <= 1'b0;
            r_data      <= '0;
            r_bit_cnt   <= '0;
            r_pat_cnt   <= '0;
            r_done_pend <= 1'b0;
            r_sig       <= '0;
            r_sig_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_test_se_q <= i_test_se;
            case (r_state)
                IDLE, DONE: begin
                    if (w_sample) begin
                        r_state     <= SHIFT;
                        r_data      <= w_data_shift;
                        r_bit_cnt   <= CW'(1);
                        r_pat_cnt   <= '0;
                        r_done_pend <= 1'b0;
                        r_sig       <= '0;
                        r_sig_valid <= 1'b0;
                        r_pass      <= 1'b0;
                        r_len_err   <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_lock_lost <= 1'b0;
                    end else if (r_state == DONE) begin
                        r_pass <= (r_sig == i_exp_sig);
                    end
                end
                default: begin
                    if (!i_adpll_lock) begin
                        r_state     <= IDLE;
                        r_bit_cnt   <= '0;
                        r_done_pend <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else if (w_boundary) begin
                        if (w_good) begin
                            r_sig <= w_sig_next;
                            if (!w_room) r_overflow <= 1'b1;
                        end else if (!w_skip) begin
                            r_len_err <= 1'b1;
                        end
                        r_pat_cnt <= r_pat_cnt + 20'd1;
                        r_bit_cnt <= '0;
                        if (r_done_pend) begin
                            r_state     <= DONE;
                            r_done_pend <= 1'b0;
                            r_sig_valid <= 1'b1;
                            r_pass      <= (w_sig_upd == i_exp_sig);
                        end else begin
                            r_state <= CAPTURE;
                            if (i_scan_done) r_done_pend <= 1'b1;
                        end
                    end else begin
                        if (i_scan_done) r_done_pend <= 1'b1;
                        if (r_state == CAPTURE && i_test_se) r_state <= SHIFT;
                        // Every gated scan_clk edge is a shift, including the one leaving CAPTURE.
                        if (w_sample) begin
                            r_data    <= w_data_shift;
                            r_bit_cnt <= w_cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (CHAIN_LEN + 20),
        .DEPTH (2)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat ({r_data, r_pat_cnt}),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    assign resp.resp_valid = ~w_empty;
    assign resp.resp_data  = w_head[CHAIN_LEN+19:20];
    assign resp.resp_idx   = w_head[19:0];
    assign o_signature     = r_sig;
    assign o_sig_valid     = r_sig_valid;
    assign o_pass          = r_pass;
    assign o_len_err       = r_len_err;
    assign o_overflow      = r_overflow;
    assign o_lock_lost     = r_lock_lost;
endmodule

// File: tb/tb_scan_response_collector.sv
// Directed bench: two collectors (SKIP_FIRST 0 and 1) share one scan stimulus stream.
module tb_scan_response_collector;
    localparam int CL = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adpll_lock, shift_en, test_se, scan_done, scan_so;
    logic [15:0] exp_sig;
    logic [15:0] sig0, sig1;
    logic        sv0, sv1, ps0, ps1, le0, le1, ov0, ov1, ll0, ll1;

    int n_cmp = 0;
    int n_bad = 0;

    scan_response_collector_if #(.CHAIN_LEN(CL)) if0 ();
    scan_response_collector_if #(.CHAIN_LEN(CL)) if1 ();

    always #5 clk = ~clk;

    scan_response_collector #(.CHAIN_LEN(CL), .SKIP_FIRST(1'b0), .POLY(16'h1021)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_adpll_lock(adpll_lock), .i_shift_en(shift_en),
        .i_test_se(test_se), .i_scan_done(scan_done), .i_scan_so(scan_so), .i_exp_sig(exp_sig),
        .resp(if0), .o_signature(sig0), .o_sig_valid(sv0), .o_pass(ps0),
        .o_len_err(le0), .o_overflow(ov0), .o_lock_lost(ll0)
    );

    scan_response_collector #(.CHAIN_LEN(CL), .SKIP_FIRST(1'b1), .POLY(16'h1021)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_adpll_lock(adpll_lock), .i_shift_en(shift_en),
        .i_test_se(test_se), .i_scan_done(scan_done), .i_scan_so(scan_so), .i_exp_sig(exp_sig),
        .resp(if1), .o_signature(sig1), .o_sig_valid(sv1), .o_pass(ps1),
        .o_len_err(le1), .o_overflow(ov1), .o_lock_lost(ll1)
    );

    typedef struct {
        logic          valid;
        logic [CL-1:0] data;
        logic [19:0]   idx;
        logic [15:0]   sig;
        logic          len_err;
        logic          ovf;
        logic          sig_valid;
        logic          pass;
    } exp_t;

    typedef struct {
        logic [CL-1:0] word;
        int            nbits;
        int            done_at;
        logic          rdy0;
        logic          rdy0_bnd;
        logic          rdy1;
        exp_t          e0;
        exp_t          e1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input exp_t e, input logic valid,
                             input logic [CL-1:0] data, input logic [19:0] idx,
                             input logic [15:0] sig, input logic le, input logic ov,
                             input logic sv, input logic ps);
        chk({tag, " resp_valid"}, 32'(valid), 32'(e.valid));
        if (e.valid) begin
            chk({tag, " resp_data"}, 32'(data), 32'(e.data));
            chk({tag, " resp_idx"},  32'(idx),  32'(e.idx));
        end
        chk({tag, " signature"}, 32'(sig), 32'(e.sig));
        chk({tag, " len_err"},   32'(le),  32'(e.len_err));
        chk({tag, " overflow"},  32'(ov),  32'(e.ovf));
        chk({tag, " sig_valid"}, 32'(sv),  32'(e.sig_valid));
        chk({tag, " pass"},      32'(ps),  32'(e.pass));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [CL-1:0] w, input int n, input int done_at);
        for (int i = 0; i < n; i++) begin
            scan_so   = w[i];
            test_se   = 1'b1;
            shift_en  = 1'b1;
            scan_done = (i == done_at);
            tick();
        end
        scan_done = 1'b0;
    endtask

    task automatic run_row(input int k);
        if0.resp_ready = vecs[k].rdy0;
        if1.resp_ready = vecs[k].rdy1;
        shift_bits(vecs[k].word, vecs[k].nbits, vecs[k].done_at);
        test_se  = 1'b0;
        shift_en = 1'b0;
        if0.resp_ready = vecs[k].rdy0_bnd;
        tick();
        check_exp($sformatf("row%0d dut0", k), vecs[k].e0, if0.resp_valid, if0.resp_data,
                  if0.resp_idx, sig0, le0, ov0, sv0, ps0);
        check_exp($sformatf("row%0d dut1", k), vecs[k].e1, if1.resp_valid, if1.resp_data,
                  if1.resp_idx, sig1, le1, ov1, sv1, ps1);
    endtask

    exp_t e_zero;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        e_zero = '{1'b0, 11'h000, 20'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        //            word     n   done rdy0  bnd   rdy1  dut0 {valid,data,idx,sig,len,ovf,sv,pass}     dut1
        vecs[0] = '{11'h5A3, 11, -1, 1'b1, 1'b1, 1'b1,
                    '{1'b1, 11'h5A3, 20'd0, 16'h05A3, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{1'b0, 11'h000, 20'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{11'h0FF, 11, -1, 1'b1, 1'b1, 1'b1,
                    '{1'b1, 11'h0FF, 20'd1, 16'h0BB9, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{1'b1, 11'h0FF, 20'd1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{11'h123, 10, 3, 1'b1, 1'b1, 1'b1,
                    '{1'b0, 11'h000, 20'd0, 16'h0BB9, 1'b1, 1'b0, 1'b1, 1'b1},
                    '{1'b0, 11'h000, 20'd0, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{11'h7FF, 11, -1, 1'b0, 1'b0, 1'b0,
                    '{1'b1, 11'h7FF, 20'd0, 16'h07FF, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{1'b0, 11'h000, 20'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{11'h001, 11, -1, 1'b0, 1'b0, 1'b0,
                    '{1'b1, 11'h7FF, 20'd0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{1'b1, 11'h001, 20'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{11'h2AA, 11, -1, 1'b0, 1'b1, 1'b0,
                    '{1'b1, 11'h001, 20'd1, 16'h1D54, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{1'b1, 11'h001, 20'd1, 16'h02A8, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{11'h400, 11, -1, 1'b0, 1'b0, 1'b0,
                    '{1'b1, 11'h001, 20'd1, 16'h3EA8, 1'b0, 1'b1, 1'b0, 1'b0},
                    '{1'b1, 11'h001, 20'd1, 16'h0150, 1'b0, 1'b1, 1'b0, 1'b0}};

        rst_n = 1'b0;
        adpll_lock = 1'b1;
        shift_en = 1'b0;
        test_se = 1'b0;
        scan_done = 1'b0;
        scan_so = 1'b0;
        exp_sig = 16'h0BB9;
        if0.resp_ready = 1'b0;
        if1.resp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_exp("reset dut0", e_zero, if0.resp_valid, if0.resp_data, if0.resp_idx,
                  sig0, le0, ov0, sv0, ps0);
        chk("reset dut0 resp_data", 32'(if0.resp_data), 32'h0);
        chk("reset dut0 resp_idx",  32'(if0.resp_idx),  32'h0);
        chk("reset dut0 lock_lost", 32'(ll0), 32'h0);
        rst_n = 1'b1;
        tick();

        // Session 1: two good words, then a short word carrying scan_done.
        for (int k = 0; k < 3; k++) run_row(k);

        // DONE holds sig_valid/pass while idle.
        repeat (2) tick();
        chk("hold dut0 sig_valid", 32'(sv0), 32'h1);
        chk("hold dut0 pass",      32'(ps0), 32'h1);
        chk("hold dut1 pass",      32'(ps1), 32'h0);

        // Session 2: restart from DONE, fill buffers, pop-at-full, then overflow.
        for (int k = 3; k < 7; k++) run_row(k);

        // Lock drops mid-word after 5 shifts.
        if0.resp_ready = 1'b0;
        if1.resp_ready = 1'b0;
        shift_bits(11'h7FF, 5, -1);
        adpll_lock = 1'b0;
        tick();
        chk("lock dut0 lock_lost", 32'(ll0), 32'h1);
        chk("lock dut1 lock_lost", 32'(ll1), 32'h1);
        chk("lock dut0 sig_valid", 32'(sv0), 32'h0);
        chk("lock dut0 signature", 32'(sig0), 32'h3EA8);
        test_se = 1'b0;
        shift_en = 1'b0;
        if0.resp_ready = 1'b1;
        if1.resp_ready = 1'b1;
        repeat (2) tick();
        chk("drain dut0 resp_valid", 32'(if0.resp_valid), 32'h0);
        chk("drain dut1 resp_valid", 32'(if1.resp_valid), 32'h0);

        // New session clears lock_lost, signature and pattern count.
        adpll_lock = 1'b1;
        if0.resp_ready = 1'b0;
        if1.resp_ready = 1'b0;
        shift_bits(11'h055, 11, -1);
        test_se = 1'b0;
        shift_en = 1'b0;
        tick();
        chk("restart dut0 lock_lost",  32'(ll0), 32'h0);
        chk("restart dut0 signature",  32'(sig0), 32'h0055);
        chk("restart dut0 resp_valid", 32'(if0.resp_valid), 32'h1);
        chk("restart dut0 resp_data",  32'(if0.resp_data), 32'h055);
        chk("restart dut0 resp_idx",   32'(if0.resp_idx), 32'h0);
        chk("restart dut0 overflow",   32'(ov0), 32'h0);
        chk("restart dut1 lock_lost",  32'(ll1), 32'h0);
        chk("restart dut1 signature",  32'(sig1), 32'h0000);
        chk("restart dut1 resp_valid", 32'(if1.resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_response_collector.md
# scan_response_collector

Receive-side companion to the slow scan controller in the ADPLL scan-test path. It sits on the chain's scan_so output and samples one bit per active scan_clk cycle, qualified by the controller's test_se, shift_en and ADPLL_LOCK. Each unloaded chain word is deserialized, checked for length, pushed into a 2-deep response buffer, and folded into a 16-bit MISR signature. At the end of the session it reports the signature and a pass/fail result against an expected value.

## Interface
- CHAIN_LEN, 11: scan flops per chain, i.e. bits per unloaded word (2..64).
- SKIP_FIRST, 1: when 1, discard the first unload of a session, since it holds the power-up chain contents.
- POLY, 16'h1021: MISR feedback polynomial.
- clk  in  1  scan controller clock; scan_clk is clk gated, so every posedge with shift active is one shift.
- rst_n  in  1  asynchronous, active-low reset.
- adpll_lock  in  1  ADPLL lock; scan_clk is active only when this is high.
- shift_en  in  1  controller shift enable (the scan_clk gate).
- test_se  in  1  scan enable; 1 = shift, 0 = capture.
- scan_done  in  1  one-cycle pulse: final pattern in progress.
- scan_so  in  1  chain serial output.
- exp_sig  in  16  expected final signature.
- resp_ready  in  1  consumer accepts the head word.
- resp_valid  out  1  buffer non-empty.
- resp_data  out  CHAIN_LEN  head word; first-shifted bit at LSB.
- resp_idx  out  20  pattern index of the head word.
- signature  out  16  running MISR value.
- sig_valid  out  1  session complete and signature final.
- pass  out  1  signature == exp_sig; meaningful only while sig_valid = 1.
- len_err  out  1  sticky: a word was discarded for wrong bit count.
- overflow  out  1  sticky: a good word was dropped because the buffer was full.
- lock_lost  out  1  sticky: lock dropped during a session.

## Operation
- FSM states: IDLE, SHIFT, CAPTURE, DONE. test_se_q is test_se registered on clk.
- sample = adpll_lock & shift_en & test_se. When sample = 1 in SHIFT: data <= {scan_so, data[CHAIN_LEN-1:1]}; bit_cnt++ (saturating at CHAIN_LEN+1).
- IDLE -> SHIFT on the first sample = 1. On this transition clear signature, bit_cnt, pattern count, done_pend, sig_valid, pass, len_err, overflow and lock_lost. The entry cycle's bit is sampled.
- DONE -> SHIFT on sample = 1, with the same clears.
- Boundary: state SHIFT, test_se_q = 1, test_se = 0. Go to CAPTURE. Then:
  - if pattern count = 0 and SKIP_FIRST = 1: discard the word;
  - else if bit_cnt != CHAIN_LEN: discard the word and set len_err;
  - else (good word): update the MISR, then push {data, pattern idx} if the buffer is not full, else set overflow.
  - In every case pattern count++ (20-bit, wraps) and bit_cnt <= 0.
- CAPTURE -> SHIFT when test_se = 1.
- MISR update: sig <= (sig<<1) ^ (sig[15] ? POLY : 0) ^ fold(data). fold = XOR of data split into 16-bit chunks, zero-extended.
- scan_done = 1 in SHIFT or CAPTURE sets done_pend. The next boundary processes its word as normal, then goes to DONE instead of CAPTURE. In DONE: sig_valid = 1 and pass = (signature == exp_sig). Both are held.
- adpll_lock = 0 in SHIFT or CAPTURE: go to IDLE, drop the partial word, set lock_lost, clear done_pend. sig_valid stays 0.
- Buffer: 2-entry FIFO. Pop on resp_valid & resp_ready. A simultaneous push and pop while full is accepted with no overflow. Buffer contents survive session restarts and are cleared only by rst_n.

## Timing
- Reset values: state IDLE; resp_valid 0; resp_data 0; resp_idx 0; signature 0; sig_valid 0; pass 0; all sticky flags 0.
- Word latency: resp_valid and the updated signature are visible after the boundary edge, i.e. 1 clk after test_se falls.
- sig_valid latency: asserts after the boundary edge that follows scan_done.
- All outputs are registered; there is no combinational path from input to output.
- resp_data and resp_idx are stable while resp_valid = 1 and resp_ready = 0.

## Test plan
- CHAIN_LEN = 11, SKIP_FIRST = 0. Shift 11'h5A3 LSB-first, then drop test_se -> resp_data = 11'h5A3, resp_idx = 0, signature = 16'h05A3.
- Next pattern 11'h0FF -> resp_idx = 1, signature = 16'h0BB9. Pulse scan_done during the next shift with exp_sig = 16'h0BB9 -> sig_valid = 1, pass = 1 one cycle after that boundary.
- A pattern with only 10 shifts -> len_err = 1, no push, signature unchanged.
- SKIP_FIRST = 1: the first unload is not pushed; the second word gets resp_idx = 1.
- resp_ready = 0, three good words -> two entries retained, overflow = 1, signature includes all three words.
- Deassert adpll_lock after 5 shifts -> lock_lost = 1, state IDLE. The next session start clears lock_lost and signature.
